// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after a pointer
module rr_arbiter #(
   parameter int NUM_CH   = 4,
   parameter int CH_WIDTH = 2
) (
   input  logic [NUM_CH-1:0]   req,
   input  logic [CH_WIDTH-1:0] ptr,
   output logic [NUM_CH-1:0]   grant,
   output logic [CH_WIDTH-1:0] grant_idx,
   output logic                grant_vld
);

   int c;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      c         = 0;
      for (int off = 0; off < NUM_CH; off++) begin
         c = (int'(ptr) + off) % NUM_CH;
         if (!grant_vld && req[c]) begin
            grant_vld = 1'b1;
            grant[c]  = 1'b1;
            grant_idx = CH_WIDTH'(c);
         end
      end
   end

endmodule

// File: rtl/axis_tstamp_arbiter.sv
// rtl/axis_tstamp_arbiter.sv - per-channel edge timestamp capture shared onto one AXI-Stream master
module axis_tstamp_arbiter #(
   parameter int AXIS_TDATA_WIDTH = 64,
   parameter int CNTR_WIDTH       = 48,
   parameter int NUM_CH           = 4,
   parameter int CH_WIDTH         = 2,
   parameter int DROP_WIDTH       = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [CNTR_WIDTH-1:0]       cntr_data,
   input  logic [NUM_CH-1:0]           evt_in,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [NUM_CH-1:0]           sts_pending,
   output logic [DROP_WIDTH-1:0]       sts_drop_cntr
);

   localparam int OVF_BIT = AXIS_TDATA_WIDTH - 1;
   localparam int CH_LSB  = AXIS_TDATA_WIDTH - 1 - CH_WIDTH;

   logic [NUM_CH-1:0]           evt_q;
   logic [NUM_CH-1:0]           evt_edge;
   logic [NUM_CH-1:0]           pending;
   logic [NUM_CH-1:0]           ovf;
   logic [CNTR_WIDTH-1:0]       slot_ts [NUM_CH];
   logic [CH_WIDTH-1:0]         rr_ptr;
   logic [DROP_WIDTH-1:0]       drop_cntr;

   logic                        load;
   logic                        do_grant;
   logic [NUM_CH-1:0]           grant;
   logic [NUM_CH-1:0]           grant_mask;
   logic [CH_WIDTH-1:0]         grant_idx;
   logic                        grant_vld;
   logic [NUM_CH-1:0]           drop_vec;
   logic [4:0]                  drop_num;
   logic [DROP_WIDTH:0]         drop_sum;
   logic [AXIS_TDATA_WIDTH-1:0] record;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .CH_WIDTH (CH_WIDTH)
   ) u_rr (
      .req       (pending),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign evt_edge   = evt_in & ~evt_q;
   assign load       = ~m_axis_tvalid | m_axis_tready;
   assign do_grant   = load & grant_vld;
   assign grant_mask = do_grant ? grant : '0;
   // A re-trigger on the slot being granted this cycle is a fresh capture, not a loss
   assign drop_vec   = evt_edge & pending & ~grant_mask;

   always_comb begin
      drop_num = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         drop_num = drop_num + {4'b0, drop_vec[i]};
      end
      drop_sum = {1'b0, drop_cntr} + (DROP_WIDTH+1)'(drop_num);
   end

   always_comb begin
      record                         = '0;
      record[OVF_BIT]                = ovf[grant_idx];
      record[CH_LSB +: CH_WIDTH]     = grant_idx;
      record[CNTR_WIDTH-1:0]         = slot_ts[grant_idx];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         evt_q         <= '1;
         pending       <= '0;
         ovf           <= '0;
         rr_ptr        <= '0;
         drop_cntr     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            slot_ts[i] <= '0;
         end
      end else begin
         evt_q <= evt_in;

         for (int i = 0; i < NUM_CH; i++) begin
            if (evt_edge[i] && (!pending[i] || grant_mask[i])) begin
               slot_ts[i] <= cntr_data;
               pending[i] <= 1'b1;
               ovf[i]     <= 1'b0;
            end else if (evt_edge[i]) begin
               ovf[i]     <= 1'b1;
            end else if (grant_mask[i]) begin
               pending[i] <= 1'b0;
               ovf[i]     <= 1'b0;
            end
         end

         if (drop_sum[DROP_WIDTH]) begin
            drop_cntr <= '1;
         end else begin
            drop_cntr <= drop_sum[DROP_WIDTH-1:0];
         end

         if (do_grant) begin
            m_axis_tdata  <= record;
            m_axis_tvalid <= 1'b1;
            rr_ptr        <= (grant_idx == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
         end else if (load) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   assign sts_pending   = pending;
   assign sts_drop_cntr = drop_cntr;

endmodule
